// File: rtl/ps2_keyboard_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder
//   PS/2 keyboard receiver and scan-code set 2 decoder for the game input path.
//   The raw open-collector PS/2 lines are synchronised into the system clock
//   domain. The keyboard clock is debounced by a level filter, and 11-bit
//   frames are deframed on its falling edges. A small decoder then tracks the
//   F0 (break) and E0 (extended) prefixes and holds the most recent key event.
//
// Ports
//   clk                 in   1  system clock, rising edge
//   rst                 in   1  asynchronous, active-high reset
//   ps2_clk             in   1  raw keyboard clock (asynchronous)
//   ps2_data            in   1  raw keyboard data (asynchronous)
//   current_scan_code   out  8  last completed key code (prefixes excluded)
//   current_make_break  out  1  1 = make (pressed), 0 = break (released)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_keyboard_decoder #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = CLK_FREQ_HZ / 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] current_scan_code,
    output logic       current_make_break
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // The filter counter reaches FILT_LAST on the FILTER_LEN-th differing sample.
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_BREAK_PEND = 1'b1
    } dec_state_t;

    logic          clk_meta_r;
    logic          clk_sync_r;
    logic          data_meta_r;
    logic          data_sync_r;
    logic          clk_filt_r;
    logic [FW-1:0] filt_cnt_r;
    logic          fall_s;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic [TW-1:0] idle_cnt_r;
    logic [7:0]    byte_r;
    logic          byte_valid_r;
    dec_state_t    state_r;
    logic          ext_r;

    // Two-flop synchronisers for both PS/2 lines, preset to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Level filter: the filtered clock follows the synchronised clock only after
    // FILTER_LEN consecutive samples disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt_r <= 1'b1;
            filt_cnt_r <= '0;
        end else if (clk_sync_r == clk_filt_r) begin
            filt_cnt_r <= '0;
        end else if (filt_cnt_r == FILT_LAST) begin
            clk_filt_r <= clk_sync_r;
            filt_cnt_r <= '0;
        end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
        end
    end

    // Fall pulse: asserted in the same cycle the filter commits a 1->0 change.
    always_comb begin
        fall_s = clk_filt_r & ~clk_sync_r & (filt_cnt_r == FILT_LAST);
    end

    // Frame receiver: shifts start, data and parity on the first ten falls. On the
    // eleventh fall, the stop bit is the live data sample. The idle counter drops
    // a stalled partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r    <= 4'd0;
            shift_r      <= 10'd0;
            idle_cnt_r   <= '0;
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            if (fall_s) begin
                idle_cnt_r <= '0;
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    // shift_r[0] is the start bit. Parity sits in shift_r[9] and is not checked.
                    if ((shift_r[0] == 1'b0) && (data_sync_r == 1'b1)) begin
                        byte_r       <= shift_r[8:1];
                        byte_valid_r <= 1'b1;
                    end else begin
                        byte_valid_r <= 1'b0;
                    end
                end else begin
                    shift_r   <= {data_sync_r, shift_r[9:1]};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (bit_cnt_r != 4'd0) begin
                if (idle_cnt_r == TO_LAST) begin
                    bit_cnt_r  <= 4'd0;
                    idle_cnt_r <= '0;
                end else begin
                    idle_cnt_r <= idle_cnt_r + TW'(1);
                end
            end else begin
                idle_cnt_r <= '0;
            end
        end
    end

    // Prefix decoder. F0 arms a break. E0 only marks an extended code; it does not
    // change the reported code, so E0 F0 xx and F0 E0 xx both give a break of xx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            ext_r              <= 1'b0;
            current_scan_code  <= 8'h00;
            current_make_break <= 1'b0;
        end else if (byte_valid_r) begin
            case (byte_r)
                8'hF0: begin
                    state_r <= ST_BREAK_PEND;
                end
                8'hE0: begin
                    ext_r <= 1'b1;
                end
                default: begin
                    current_scan_code  <= byte_r;
                    current_make_break <= (state_r == ST_IDLE) ? 1'b1 : 1'b0;
                    state_r            <= ST_IDLE;
                    if (ext_r) begin
                        ext_r <= 1'b0;
                    end else begin
                        ext_r <= 1'b0;
                    end
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
`timescale 1ns/1ps

module tb_ps2_keyboard_decoder;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 500;
    localparam int HALF        = 200;   // ps2_clk half period in ns

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] current_scan_code;
    logic       current_make_break;

    int tests_run;
    int tests_failed;

    // Reference model: the key event implied by the valid bytes sent so far
    logic [7:0] m_scan;
    logic       m_mb;
    logic       m_brk;

    ps2_keyboard_decoder #(
        .CLK_FREQ_HZ (100_000_000),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ps2_clk            (ps2_clk),
        .ps2_data           (ps2_data),
        .current_scan_code  (current_scan_code),
        .current_make_break (current_make_break)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got code=%02h mb=%0b, expected code=%02h mb=%0b",
                     tag, got[8:1], got[0], exp[8:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_scan = 8'h00;
        m_mb   = 1'b0;
        m_brk  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hE0) begin
            m_scan = b;
            m_mb   = ~m_brk;
            m_brk  = 1'b0;
        end
    endtask

    task automatic expect_model(input string tag);
        check(tag, {current_scan_code, current_make_break}, {m_scan, m_mb});
    endtask

    // Drive nedges bits of a frame. glitch_at >= 0 adds a 50 ns low glitch in
    // that bit's high phase.
    task automatic send_frame(input logic [7:0] b, input bit good_start, input bit good_stop,
                              input bit par, input int nedges, input int glitch_at);
        logic [10:0] bits;
        bits = {good_stop, par, b, ~good_start};
        for (int i = 0; i < nedges; i++) begin
            ps2_data = bits[i];
            #(HALF);
            ps2_clk = 1'b0;
            #(HALF);
            ps2_clk = 1'b1;
            if (i == glitch_at) begin
                #100;
                ps2_clk = 1'b0;
                #50;
                ps2_clk = 1'b1;
                #50;
            end
        end
        ps2_data = 1'b1;
        #(2*HALF);
    endtask

    // Full well-formed frame, with the model updated
    task automatic send_key(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b1, ^b, 11, -1);
        model_byte(b);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst      = 1'b1;
        #100;
        rst = 1'b0;
        #100;
        expect_model("reset");

        send_key(8'h1C);  expect_model("make_1C");
        send_key(8'hF0);  expect_model("f0_hold");
        send_key(8'h1C);  expect_model("break_1C");
        send_key(8'hE0);  expect_model("e0_hold");
        send_key(8'h75);  expect_model("ext_make_75");
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);  expect_model("ext_break_75");
        send_key(8'h1C);
        send_key(8'hF0);
        send_key(8'hE0);
        send_key(8'h75);  expect_model("f0e0_break_75");

        // A bad stop bit or bad start bit drops the frame.
        send_frame(8'h29, 1'b1, 1'b0, 1'b1, 11, -1);  expect_model("bad_stop");
        send_key(8'h29);                              expect_model("make_29");
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 11, -1);  expect_model("bad_start");

        // A partial frame, then a long idle, is dropped by the timeout.
        send_frame(8'h33, 1'b1, 1'b1, 1'b0, 4, -1);
        #(2 * TIMEOUT_CYC * 10);
        expect_model("timeout_hold");
        send_key(8'h6B);  expect_model("timeout_6B");

        // Short ps2_clk glitch mid-frame
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 11, 5);
        model_byte(8'h3C);
        expect_model("glitch_3C");

        // Reset in the middle of a frame
        send_key(8'hF0);
        send_frame(8'h44, 1'b1, 1'b1, 1'b1, 6, -1);
        rst = 1'b1;
        #50;
        rst = 1'b0;
        #100;
        model_reset();
        expect_model("midframe_rst");
        send_key(8'h12);  expect_model("after_rst_12");

        // Randomised traffic: prefixes, plain codes and malformed frames
        for (int n = 0; n < 60; n++) begin
            int          r;
            logic [7:0]  b;
            bit          gs;
            bit          gp;
            r  = $urandom_range(0, 19);
            b  = 8'($urandom_range(0, 255));
            gs = 1'b1;
            gp = 1'b1;
            if (r <= 2) b = 8'hF0;
            else if (r <= 4) b = 8'hE0;
            else if (r == 5) gs = 1'b0;
            else if (r == 6) gp = 1'b0;
            send_frame(b, gs, gp, 1'($urandom_range(0, 1)), 11, -1);
            if (gs && gp) model_byte(b);
            expect_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
